// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if
// Instruction-memory fetch handshake between the PC sequencer and the
// instruction memory.
//   imem_req  : sequencer requests a fetch (held until imem_ack)
//   imem_addr : fetch address, equal to the sequencer's pc
//   imem_ack  : memory has the instruction; only meaningful while imem_req=1
interface pc_sequencer_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;

    modport master (output imem_req, output imem_addr, input imem_ack);
    modport slave  (input imem_req, input imem_addr, output imem_ack);
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer
// Owns the architectural PC. Runs a FETCH (req/ack) then EXEC cycle per
// instruction, selects the next PC (pc+4, pc+ImmExt, or jalr target) and
// stops in a sticky trap on a misaligned target. Counts retired instructions.
//
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   imem                  fetch handshake (master side)
//   instr_valid           high in every EXEC cycle
//   stall                 hold in EXEC
//   branch, cond_true     conditional branch and its outcome
//   jump, jalr            jal / jalr
//   ImmExt, rs1           sign-extended immediate, jalr base
//   pc, pc_plus4          current PC and pc+4 (combinational)
//   trap, trap_pc         sticky misaligned-target trap and offending PC
//   instret               retired-instruction counter
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | one cycle after reset release
// FETCH  | imem_req high, wait for imem_ack
// EXEC   | instr_valid high; commit next pc unless stalled
// TRAP   | misaligned target seen; frozen until reset
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    pc_sequencer_if.master        imem,
    output logic                  instr_valid,
    input  logic                  stall,
    input  logic                  branch,
    input  logic                  cond_true,
    input  logic                  jump,
    input  logic                  jalr,
    input  logic [31:0]           ImmExt,
    input  logic [31:0]           rs1,
    output logic [31:0]           pc,
    output logic [31:0]           pc_plus4,
    output logic                  trap,
    output logic [31:0]           trap_pc,
    output logic [31:0]           instret
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2,
        S_TRAP  = 2'd3
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] pc_nxt;
    logic [31:0] instret_nxt;
    logic [31:0] trap_pc_nxt;
    logic        trap_nxt;
    logic [31:0] target;

    assign pc_plus4       = pc + 32'd4;
    assign imem.imem_addr = pc;
    // Decoded from state so both drop the instant reset is asserted.
    assign imem.imem_req  = (state == S_FETCH);
    assign instr_valid    = (state == S_EXEC);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            pc      <= RESET_PC;
            instret <= 32'd0;
            trap    <= 1'b0;
            trap_pc <= 32'd0;
        end else begin
            state   <= state_nxt;
            pc      <= pc_nxt;
            instret <= instret_nxt;
            trap    <= trap_nxt;
            trap_pc <= trap_pc_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        pc_nxt      = pc;
        instret_nxt = instret;
        trap_nxt    = trap;
        trap_pc_nxt = trap_pc;

        // Priority jalr > jump > taken branch > fall-through.
        target = pc_plus4;
        if (jalr) begin
            target = (rs1 + ImmExt) & 32'hFFFF_FFFE;
        end else if (jump || (branch && cond_true)) begin
            target = pc + ImmExt;
        end

        case (state)
            S_IDLE: begin
                state_nxt = S_FETCH;
            end
            S_FETCH: begin
                if (imem.imem_ack) begin
                    state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                if (!stall) begin
                    if (target[1:0] != 2'b00) begin
                        state_nxt   = S_TRAP;
                        trap_nxt    = 1'b1;
                        trap_pc_nxt = pc;
                    end else begin
                        state_nxt   = S_FETCH;
                        pc_nxt      = target;
                        instret_nxt = instret + 32'd1;
                    end
                end
            end
            S_TRAP: begin
                state_nxt = S_TRAP;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        instr_valid;
    logic        stall = 1'b0;
    logic        branch = 1'b0;
    logic        cond_true = 1'b0;
    logic        jump = 1'b0;
    logic        jalr = 1'b0;
    logic [31:0] ImmExt = 32'd0;
    logic [31:0] rs1 = 32'd0;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        trap;
    logic [31:0] trap_pc;
    logic [31:0] instret;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    pc_sequencer_if imem_bus ();

    pc_sequencer #(.RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem        (imem_bus),
        .instr_valid (instr_valid),
        .stall       (stall),
        .branch      (branch),
        .cond_true   (cond_true),
        .jump        (jump),
        .jalr        (jalr),
        .ImmExt      (ImmExt),
        .rs1         (rs1),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .trap        (trap),
        .trap_pc     (trap_pc),
        .instret     (instret)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    // Phase of the instruction lifecycle the model believes the DUT is in.
    localparam int P_IDLE = 0, P_FETCH = 1, P_EXEC = 2, P_HALT = 3;
    int          m_phase;
    logic [31:0] m_pc, m_instret, m_trap_pc;
    logic        m_trap;

    // At each falling edge: compare, then advance the model by what the
    // next rising edge will do with the inputs now on the pins.
    always @(negedge clk) begin
        logic [31:0] t;
        if (!rst_n) begin
            m_phase   = P_IDLE;
            m_pc      = 32'd0;
            m_instret = 32'd0;
            m_trap    = 1'b0;
            m_trap_pc = 32'd0;
        end
        chk("imem_req",    {31'd0, imem_bus.imem_req}, {31'd0, (m_phase == P_FETCH)});
        chk("instr_valid", {31'd0, instr_valid}, {31'd0, (m_phase == P_EXEC)});
        chk("pc",          pc, m_pc);
        chk("imem_addr",   imem_bus.imem_addr, m_pc);
        chk("pc_plus4",    pc_plus4, m_pc + 32'd4);
        chk("trap",        {31'd0, trap}, {31'd0, m_trap});
        chk("trap_pc",     trap_pc, m_trap_pc);
        chk("instret",     instret, m_instret);
        if (rst_n) begin
            if (m_phase == P_IDLE) begin
                m_phase = P_FETCH;
            end else if (m_phase == P_FETCH) begin
                if (imem_bus.imem_ack) m_phase = P_EXEC;
            end else if (m_phase == P_EXEC && !stall) begin
                if (jalr)                        t = ((rs1 + ImmExt) >> 1) << 1;
                else if (jump)                   t = m_pc + ImmExt;
                else if (branch && cond_true)    t = m_pc + ImmExt;
                else                             t = m_pc + 32'd4;
                if (t % 4 != 0) begin
                    m_trap    = 1'b1;
                    m_trap_pc = m_pc;
                    m_phase   = P_HALT;
                end else begin
                    m_pc      = t;
                    m_instret = m_instret + 32'd1;
                    m_phase   = P_FETCH;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_ctrl();
        stall = 0; branch = 0; cond_true = 0; jump = 0; jalr = 0;
        ImmExt = 32'd0; rs1 = 32'd0;
    endtask

    task automatic exec_one(input logic br, input logic ct, input logic jp, input logic jr,
                            input logic [31:0] imm, input logic [31:0] r1,
                            output logic [31:0] pc_at_exec);
        int n = 0;
        imem_bus.imem_ack = 1'b1;
        stall = 0; branch = br; cond_true = ct; jump = jp; jalr = jr;
        ImmExt = imm; rs1 = r1;
        while (instr_valid !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        chk("exec_reached", {31'd0, instr_valid}, 32'd1);
        pc_at_exec = pc;
        step();
        clear_ctrl();
    endtask

    initial begin
        logic [31:0] p;
        logic [31:0] addr0;
        int n;
        int vcnt;

        imem_bus.imem_ack = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_pc", pc, 32'h0);
        chk("rst_req", {31'd0, imem_bus.imem_req}, 32'd0);
        chk("rst_instret", instret, 32'd0);
        step();
        rst_n = 1'b1;

        // sequential fetch
        exec_one(0, 0, 0, 0, 32'd0, 32'd0, p); chk("seq_pc0", p, 32'h0);
        exec_one(0, 0, 0, 0, 32'd0, 32'd0, p); chk("seq_pc1", p, 32'h4);
        exec_one(0, 0, 0, 0, 32'd0, 32'd0, p); chk("seq_pc2", p, 32'h8);
        chk("seq_instret", instret, 32'd3);
        chk("seq_pc_end", pc, 32'hC);

        // branches
        exec_one(0, 0, 1, 0, 32'h0000_00F4, 32'd0, p);
        chk("jal_to_100", pc, 32'h100);
        exec_one(1, 1, 0, 0, 32'hFFFF_FFF0, 32'd0, p);
        chk("br_taken_pc", pc, 32'hF0);
        chk("br_taken_instret", instret, 32'd5);
        exec_one(0, 0, 1, 0, 32'h0000_0010, 32'd0, p);
        exec_one(1, 0, 0, 0, 32'hFFFF_FFF0, 32'd0, p);
        chk("br_not_taken_pc", pc, 32'h104);

        // jalr priority with odd target
        exec_one(0, 0, 1, 1, 32'h3, 32'h2001, p);
        chk("jalr_prio_pc", pc, 32'h2004);
        chk("jalr_instret", instret, 32'd8);

        // misaligned trap
        exec_one(0, 0, 0, 1, 32'h0, 32'h40, p);
        chk("to_40", pc, 32'h40);
        exec_one(0, 0, 1, 0, 32'h6, 32'd0, p);
        chk("trap_set", {31'd0, trap}, 32'd1);
        chk("trap_pc_val", trap_pc, 32'h40);
        chk("trap_pc_hold", pc, 32'h40);
        chk("trap_instret", instret, 32'd9);
        imem_bus.imem_ack = 1'b1; jump = 1; branch = 1; cond_true = 1; ImmExt = 32'h8;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("trap_req_low", {31'd0, imem_bus.imem_req}, 32'd0);
            chk("trap_valid_low", {31'd0, instr_valid}, 32'd0);
        end
        clear_ctrl();
        rst_n = 1'b0;
        #1;
        chk("trap_clr", {31'd0, trap}, 32'd0);
        chk("trap_rst_pc", pc, 32'h0);
        #1;
        step();
        rst_n = 1'b1;

        // slow ack then stall
        imem_bus.imem_ack = 1'b0;
        n = 0;
        while (imem_bus.imem_req !== 1'b1 && n < 10) begin
            step();
            n++;
        end
        addr0 = imem_bus.imem_addr;
        for (int i = 0; i < 5; i++) begin
            chk("slow_req", {31'd0, imem_bus.imem_req}, 32'd1);
            chk("slow_addr", imem_bus.imem_addr, 32'h0);
            step();
        end
        imem_bus.imem_ack = 1'b1;
        stall = 1;
        step();
        imem_bus.imem_ack = 1'b0;
        vcnt = 0;
        for (int i = 0; i < 3; i++) begin
            if (instr_valid === 1'b1) vcnt++;
            chk("stall_pc", pc, addr0);
            step();
        end
        stall = 0;
        if (instr_valid === 1'b1) vcnt++;
        step();
        chk("stall_valid_cycles", vcnt, 32'd4);
        chk("stall_pc_after", pc, 32'h4);
        chk("stall_instret", instret, 32'd1);

        // async reset mid-FETCH
        chk("mid_fetch_req", {31'd0, imem_bus.imem_req}, 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_req_drop", {31'd0, imem_bus.imem_req}, 32'd0);
        chk("async_pc", pc, 32'h0);
        step();
        rst_n = 1'b1;

        // wrap-around
        exec_one(0, 0, 0, 1, 32'h0, 32'hFFFF_FFFC, p);
        chk("wrap_start", pc, 32'hFFFF_FFFC);
        exec_one(0, 0, 0, 0, 32'h0, 32'h0, p);
        chk("wrap_pc", pc, 32'h0);
        chk("wrap_no_trap", {31'd0, trap}, 32'd0);
        chk("wrap_instret", instret, 32'd2);

        // randomized run
        for (int i = 0; i < 3000; i++) begin
            if ((trap === 1'b1 && $urandom_range(0, 7) == 0) || $urandom_range(0, 499) == 0) begin
                rst_n = 1'b0;
                step();
                rst_n = 1'b1;
            end
            imem_bus.imem_ack = ($urandom_range(0, 9) < 7);
            stall     = ($urandom_range(0, 3) == 0);
            jalr      = ($urandom_range(0, 9) == 0);
            jump      = ($urandom_range(0, 19) < 3);
            branch    = ($urandom_range(0, 9) < 3);
            cond_true = $urandom_range(0, 1) == 1;
            ImmExt    = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 19) == 0) ImmExt = ImmExt | 32'($urandom_range(1, 3));
            rs1       = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 9) == 0) rs1 = rs1 | 32'($urandom_range(1, 3));
            step();
        end
        clear_ctrl();
        step();
        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
